branch_cond_arbiter: RTL and testbench
======================================

// Module: branch_cond_arbiter
// PURPOSE
//  Shares one branch-condition evaluator (two zero_check instances plus compare logic) between
//  NREQ core pipelines. Each core's decode stage presents operands and a condition op.
//  A round-robin arbiter grants at most one request per cycle and evaluates it.
//  One cycle later the requester receives a registered taken/not-taken pulse.
// PARAMETERS
//  N      32  operand width in bits
//  NREQ   4   number of requesters (cores); >=2
// PORTS
//  clk         in   1            clock; all state updates on rising edge
//  rst_n       in   1            asynchronous, active-low reset
//  hold        in   1            1 = grant nothing this cycle; RR pointer frozen
//  req_valid   in   NREQ         request pending, per requester
//  req_ready   out  NREQ         one-hot (or zero) grant; combinational from req_valid/ptr/hold
//  req_a       in   NREQ x N     operand A (rs), per requester
//  req_b       in   NREQ x N     operand B (rt), per requester
//  req_op      in   NREQ x 2     condition: 00 EQ, 01 NE, 10 LEZ, 11 GTZ
//  resp_valid  out  NREQ         one-cycle pulse to the requester granted in the previous cycle
//  resp_id     out  $clog2(NREQ) index of the responding requester
//  resp_taken  out  1            branch condition result; qualified by |resp_valid
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): ptr=0, resp_valid='0, resp_id=0, resp_taken=0.
//  - Handshake: transfer for requester i when req_valid[i] && req_ready[i].
//    Requester holds valid, a, b and op stable until ready. req_ready never asserts without req_valid.
//  - Arbitration: scan i = ptr, ptr+1, ... mod NREQ. The first i with req_valid[i]=1 is granted.
//    On grant, ptr <= (i+1) mod NREQ.
//    With no valid request or hold=1: no grant, ptr unchanged.
//  - Evaluate (combinational on the granted lane):
//    EQ: zero(a^b); NE: !zero(a^b); LEZ: zero(a) | a[N-1]; GTZ: !zero(a) & !a[N-1].
//    Operands are two's-complement; no subtraction (no overflow cases).
//  - Latency: exactly 1 cycle. At edge k with grant i: resp_valid <= onehot(i), resp_id <= i,
//    resp_taken <= result.
//    With no grant: resp_valid <= '0. resp_id and resp_taken hold their previous values.
//  - Throughput: 1 evaluation/cycle. A requester may re-request in the cycle its response is
//    visible. It wins again only if no other lane is valid.
//  - Fairness: a continuously valid requester is granted within NREQ cycles (hold=0).
//  - Simultaneous events: all lanes valid -> grant ptr lane.
//    hold rising while a lane waits -> lane keeps waiting, no response.
//  - Reset mid-operation: an in-flight response is discarded (resp_valid cleared).
//    Requesters re-issue after reset.
//  - Wrap-around: grant to NREQ-1 sets ptr=0.
// STRUCTURE
//  - Shared package (mips_pkg): typedef enum logic [1:0] br_op_t {BR_EQ, BR_NE, BR_LEZ, BR_GTZ}.
//  - Reuses the existing zero_check #(N): one instance on a^b, one on a.
//  - One new sub-module: rr_arbiter #(NREQ) (req, hold -> one-hot grant, grant index, ptr register).
//  - This top level: operand mux, condition logic, response register.
// TESTING (N=32, NREQ=4)
//  1 Reset: rst_n=0 mid-cycle with a grant pending -> all outputs 0 immediately;
//    after release first grant goes to lane 0.
//  2 Single EQ: lane 2 valid, a=b=32'hDEADBEEF, op=EQ -> req_ready=4'b0100;
//    next cycle resp_valid=4'b0100, resp_id=2, taken=1. Then b=32'hDEADBEEE -> taken=0.
//  3 Sign ops: LEZ a=0 -> 1; LEZ a=32'h8000_0000 -> 1; GTZ a=1 -> 1; GTZ a=32'hFFFF_FFFF -> 0;
//    NE a=5 b=5 -> 0.
//  4 Round-robin: all 4 lanes valid continuously -> grants 0,1,2,3,0 on consecutive cycles;
//    each resp_id matches the grant one cycle later.
//  5 Hold: lanes 1 and 3 valid, hold=1 for 3 cycles -> req_ready=0, resp_valid=0, ptr frozen;
//    release -> lane 1 then lane 3.
//  6 Fairness/wrap: lanes 0 and 3 valid, ptr=3 -> grant 3, ptr wraps to 0, then grant 0;
//    no lane waits more than 4 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-core definitions used by the branch-condition evaluator.
package mips_pkg;

    // Width of the branch condition opcode carried by each requester.
    localparam int BR_OP_W = 2;

    // Branch condition selected by the decode stage.
    typedef enum logic [BR_OP_W-1:0] {
        BR_EQ  = 2'b00,
        BR_NE  = 2'b01,
        BR_LEZ = 2'b10,
        BR_GTZ = 2'b11
    } br_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan at ptr, ptr advances past the winner.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;

    // (base + off) mod NREQ; both terms are below NREQ so one subtraction suffices.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        logic [IW:0] sum;
        sum = {1'b0, base} + (IW+1)'(off);
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        return sum[IW-1:0];
    endfunction

    // Scan lanes from ptr upwards; the first valid lane wins unless hold is set.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (!hold) begin
            for (int off = 0; off < NREQ; off++) begin
                if (!grant_vld && req[wrap_add(ptr, off)]) begin
                    grant_vld                  = 1'b1;
                    grant_idx                  = wrap_add(ptr, off);
                    grant[wrap_add(ptr, off)]  = 1'b1;
                end
            end
        end
    end

    // Next pointer sits just past the winner, wrapping from the last lane to lane 0.
    always_comb begin
        ptr_nxt = ptr;
        if (grant_vld) begin
            ptr_nxt = (grant_idx == LAST) ? '0 : grant_idx + IW'(1);
        end
    end

    // Pointer register; frozen whenever nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/zero_check.sv
// Reports whether an N-bit word is all zeros.
module zero_check #(
    parameter int N = 32
) (
    input  logic [N-1:0] data,
    output logic         zero
);

    assign zero = ~|data;

endmodule

// File: rtl/branch_cond_arbiter.sv
// Shared branch-condition evaluator for NREQ core pipelines: round-robin grant,
// combinational condition evaluation on the granted lane, registered one-cycle response.
module branch_cond_arbiter
    import mips_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            hold,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0][N-1:0]          req_a,
    input  logic [NREQ-1:0][N-1:0]          req_b,
    input  logic [NREQ-1:0][BR_OP_W-1:0]    req_op,
    output logic [NREQ-1:0]                 resp_valid,
    output logic [IW-1:0]                   resp_id,
    output logic                            resp_taken
);

    logic [NREQ-1:0] grant_p0;
    logic [IW-1:0]   grant_idx_p0;
    logic            vld_p0;

    logic signed [N-1:0] a_p0;
    logic signed [N-1:0] b_p0;
    br_op_t              op_p0;
    logic [N-1:0]        ab_xor_p0;
    logic                zero_ab_p0;
    logic                zero_a_p0;
    logic                taken_p0;

    logic [NREQ-1:0] resp_vld_p1;
    logic [IW-1:0]   resp_id_p1;
    logic            resp_taken_p1;

    // Condition result from the two zero detectors and the sign bit of A.
    function automatic logic br_eval(input br_op_t op, input logic zero_ab,
                                     input logic zero_a, input logic a_neg);
        logic res;
        case (op)
            BR_EQ:   res = zero_ab;
            BR_NE:   res = !zero_ab;
            BR_LEZ:  res = zero_a | a_neg;
            BR_GTZ:  res = !zero_a & !a_neg;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // ---- stage p0: arbitration, operand select, condition evaluation ----
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req       (req_valid),
        .grant     (grant_p0),
        .grant_idx (grant_idx_p0),
        .grant_vld (vld_p0)
    );

    assign req_ready = grant_p0;

    // Route the granted lane's operands and opcode to the shared evaluator.
    always_comb begin
        a_p0  = req_a[grant_idx_p0];
        b_p0  = req_b[grant_idx_p0];
        op_p0 = br_op_t'(req_op[grant_idx_p0]);
    end

    assign ab_xor_p0 = a_p0 ^ b_p0;

    zero_check #(
        .N (N)
    ) u_zero_ab (
        .data (ab_xor_p0),
        .zero (zero_ab_p0)
    );

    zero_check #(
        .N (N)
    ) u_zero_a (
        .data (a_p0),
        .zero (zero_a_p0)
    );

    assign taken_p0 = br_eval(op_p0, zero_ab_p0, zero_a_p0, a_p0[N-1]);

    // ---- stage p1: registered response ----
    // Response register: valid pulses for one cycle; id/taken hold when nothing was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_p1   <= '0;
            resp_id_p1    <= '0;
            resp_taken_p1 <= 1'b0;
        end else begin
            resp_vld_p1 <= grant_p0;
            if (vld_p0) begin
                resp_id_p1    <= grant_idx_p0;
                resp_taken_p1 <= taken_p0;
            end
        end
    end

    assign resp_valid = resp_vld_p1;
    assign resp_id    = resp_id_p1;
    assign resp_taken = resp_taken_p1;

endmodule

// File: tb/tb_branch_cond_arbiter.sv
// Directed bench for branch_cond_arbiter (N=32, NREQ=4).
module tb_branch_cond_arbiter;
    import mips_pkg::*;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     hold;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][N-1:0]   req_a;
    logic [NREQ-1:0][N-1:0]   req_b;
    logic [NREQ-1:0][1:0]     req_op;
    logic [NREQ-1:0]          resp_valid;
    logic [IW-1:0]            resp_id;
    logic                     resp_taken;

    int checks   = 0;
    int failures = 0;

    branch_cond_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_taken (resp_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Single-lane evaluation; called just after a rising edge.
    task automatic eval_one(input string tag, input int lane, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic exp_t);
        req_valid       = '0;
        req_valid[lane] = 1'b1;
        req_op[lane]    = op;
        req_a[lane]     = a;
        req_b[lane]     = b;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1 << lane);
        @(posedge clk); #1;
        chk({tag, "_rvalid"}, 64'(resp_valid), 64'd1 << lane);
        chk({tag, "_rid"}, 64'(resp_id), 64'(lane));
        chk({tag, "_taken"}, 64'(resp_taken), 64'(exp_t));
        req_valid = '0;
    endtask

    initial begin
        int exp_l;
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 64'(resp_valid), 64'd0);
        chk("rst_rid", 64'(resp_id), 64'd0);
        chk("rst_taken", 64'(resp_taken), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;

        // Single EQ on lane 2, then mismatching operands
        eval_one("eq_hit", 2, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        eval_one("eq_miss", 2, 2'b00, 32'hDEADBEEF, 32'hDEADBEEE, 1'b0);
        @(posedge clk); #1;
        chk("idle_rvalid", 64'(resp_valid), 64'd0);
        chk("idle_rid_hold", 64'(resp_id), 64'd2);
        chk("idle_taken_hold", 64'(resp_taken), 64'd0);

        // Sign-sensitive ops on lane 1
        eval_one("lez_zero", 1, 2'b10, 32'h0000_0000, 32'h0, 1'b1);
        eval_one("lez_neg", 1, 2'b10, 32'h8000_0000, 32'h0, 1'b1);
        eval_one("lez_pos", 1, 2'b10, 32'h0000_0001, 32'h0, 1'b0);
        eval_one("gtz_one", 1, 2'b11, 32'h0000_0001, 32'h0, 1'b1);
        eval_one("gtz_m1", 1, 2'b11, 32'hFFFF_FFFF, 32'h0, 1'b0);
        eval_one("gtz_zero", 1, 2'b11, 32'h0000_0000, 32'h0, 1'b0);
        eval_one("ne_eq", 1, 2'b01, 32'd5, 32'd5, 1'b0);
        eval_one("ne_diff", 1, 2'b01, 32'd5, 32'd6, 1'b1);
        // Lane 3 grant brings the pointer back to 0
        eval_one("gtz_lane3", 3, 2'b11, 32'd7, 32'd0, 1'b1);

        // Round-robin: all lanes valid, lane i compares a=i with b=0
        for (int i = 0; i < NREQ; i++) begin
            req_a[i]  = 32'(i);
            req_b[i]  = '0;
            req_op[i] = 2'b00;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_l = k % NREQ;
            @(negedge clk);
            chk($sformatf("rr%0d_ready", k), 64'(req_ready), 64'd1 << exp_l);
            @(posedge clk); #1;
            chk($sformatf("rr%0d_rvalid", k), 64'(resp_valid), 64'd1 << exp_l);
            chk($sformatf("rr%0d_rid", k), 64'(resp_id), 64'(exp_l));
            chk($sformatf("rr%0d_taken", k), 64'(resp_taken), 64'(exp_l == 0));
        end
        req_valid = '0;

        // Hold with lanes 1 and 3 waiting; pointer sits at 1
        req_valid = 4'b1010;
        hold      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ready", k), 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("hold%0d_rvalid", k), 64'(resp_valid), 64'd0);
        end
        hold = 1'b0;
        @(negedge clk);
        chk("rel_ready1", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        chk("rel_rid1", 64'(resp_id), 64'd1);
        chk("rel_rvalid1", 64'(resp_valid), 64'b0010);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("rel_ready3", 64'(req_ready), 64'b1000);
        @(posedge clk); #1;
        chk("rel_rid3", 64'(resp_id), 64'd3);
        req_valid = '0;

        // Wrap: move pointer to 3, then lanes 0 and 3 valid continuously
        eval_one("pre_wrap", 2, 2'b00, 32'd1, 32'd1, 1'b1);
        req_op[0] = 2'b10;
        req_a[0]  = 32'h0;
        req_op[3] = 2'b11;
        req_a[3]  = 32'h8000_0000;
        req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            exp_l = (k % 2 == 0) ? 3 : 0;
            @(negedge clk);
            chk($sformatf("wrap%0d_ready", k), 64'(req_ready), 64'd1 << exp_l);
            @(posedge clk); #1;
            chk($sformatf("wrap%0d_rid", k), 64'(resp_id), 64'(exp_l));
            chk($sformatf("wrap%0d_taken", k), 64'(resp_taken), 64'(exp_l == 0));
        end
        req_valid = '0;

        // Reset mid-operation with a response visible and lane 2 pending
        req_op[1]  = 2'b00;
        req_a[1]   = 32'h0;
        req_b[1]   = 32'h0;
        req_valid  = 4'b0010;
        @(negedge clk);
        chk("mid_ready1", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        chk("mid_rvalid1", 64'(resp_valid), 64'b0010);
        chk("mid_taken1", 64'(resp_taken), 64'd1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("mid_pending", 64'(req_ready), 64'b0100);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_rvalid", 64'(resp_valid), 64'd0);
        chk("mid_rst_rid", 64'(resp_id), 64'd0);
        chk("mid_rst_taken", 64'(resp_taken), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        chk("post_rst_rvalid", 64'(resp_valid), 64'b0001);
        chk("post_rst_rid", 64'(resp_id), 64'd0);
        chk("post_rst_taken", 64'(resp_taken), 64'd1);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
